cb_safe_cpu_sequencer: RTL and testbench

//  Consumes the safe-CPU control fields (start, master core, mode, configuration, boot address) and drives the cores.

---
 rtl/cb_safe_seq_pkg.sv | 29 ++
 rtl/cb_core_mask_dec.sv | 31 +++
 rtl/cb_safe_cpu_sequencer.sv | 153 +++++++++++++++
 tb/tb_cb_safe_cpu_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_safe_seq_pkg.sv
// Shared types and helpers for the safe-CPU sequencer: FSM states,
// redundancy configuration encodings and one-hot master decoding.
package cb_safe_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_BOOT,
        ST_RUN,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0] CFG_SINGLE = 2'b00;
    localparam logic [1:0] CFG_DMR    = 2'b01;
    localparam logic [1:0] CFG_TMR    = 2'b10;

    // Non-one-hot inputs fall back to core 0.
    function automatic logic [1:0] onehot2idx(input logic [2:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        if (onehot == 3'b010) begin
            idx = 2'd1;
        end else if (onehot == 3'b100) begin
            idx = 2'd2;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cb_core_mask_dec.sv
// Decodes master select, safe mode and redundancy configuration into the
// active core mask, flagging master selects that are not one-hot.
module cb_core_mask_dec
    import cb_safe_seq_pkg::*;
(
    input  logic [2:0] master_core,
    input  logic       safe_mode,
    input  logic [1:0] safe_configuration,
    output logic [2:0] mask,
    output logic       invalid
);

    logic [1:0] master_idx;
    logic [1:0] partner_idx;

    always_comb begin
        invalid     = (master_core == 3'b000) ||
                      ((master_core & (master_core - 3'd1)) != 3'b000);
        master_idx  = invalid ? 2'd0 : onehot2idx(master_core);
        partner_idx = (master_idx == 2'd2) ? 2'd0 : master_idx + 2'd1;
        mask        = 3'b001 << master_idx;
        if (safe_mode) begin
            case (safe_configuration)
                CFG_DMR: mask = (3'b001 << master_idx) | (3'b001 << partner_idx);
                CFG_TMR: mask = 3'b111;
                default: mask = 3'b001 << master_idx;
            endcase
        end
    end

endmodule

// File: rtl/cb_safe_cpu_sequencer.sv
// Sequences the 3-core safe CPU wrapper through halt, reset/boot, run and
// completion, reporting completion to the control registers on end_sw_o.
module cb_safe_cpu_sequencer
    import cb_safe_seq_pkg::*;
#(
    parameter int NCORES     = 3,
    parameter int RST_CYCLES = 8,
    parameter int TIMEOUT_W  = 24
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [2:0]        master_core_i,
    input  logic              safe_mode_i,
    input  logic [1:0]        safe_configuration_i,
    input  logic [31:0]       boot_addr_i,
    input  logic [NCORES-1:0] core_halted_i,
    input  logic [NCORES-1:0] core_done_i,
    output logic [NCORES-1:0] core_debug_req_o,
    output logic [NCORES-1:0] core_rst_no,
    output logic [NCORES-1:0] core_fetch_en_o,
    output logic [31:0]       core_boot_addr_o,
    output logic              end_sw_o,
    output logic              busy_o,
    output logic              error_o
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int CNT_W = (TIMEOUT_W > RST_W) ? TIMEOUT_W : RST_W;
    localparam bit WD_EN = (TIMEOUT_W > 0);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES);
    // The watchdog trips on the RUN cycle in which the count would reach all-ones.
    localparam logic [CNT_W-1:0] WD_LAST =
        (TIMEOUT_W > 0) ? CNT_W'((64'd1 << TIMEOUT_W) - 64'd2) : '0;

    seq_state_t        state_q, state_d;
    logic              start_q;
    logic              armed_q;
    logic              start_rise;
    logic [NCORES-1:0] done_q;
    logic [NCORES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       boot_q, boot_d;
    logic              error_q, error_d;
    logic [2:0]        dec_mask;
    logic              dec_invalid;

    cb_core_mask_dec u_mask_dec (
        .master_core        (master_core_i),
        .safe_mode          (safe_mode_i),
        .safe_configuration (safe_configuration_i),
        .mask               (dec_mask),
        .invalid            (dec_invalid)
    );

    // armed_q blocks a start level that was already high when reset released.
    assign start_rise = start_i & ~start_q & armed_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            armed_q <= 1'b0;
            done_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            boot_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            armed_q <= armed_q | ~start_i;
            done_q  <= core_done_i;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        mask_d           = mask_q;
        cnt_d            = cnt_q;
        boot_d           = boot_q;
        error_d          = error_q;
        core_debug_req_o = '0;
        core_rst_no      = '1;
        core_fetch_en_o  = '0;
        end_sw_o         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_HALT;
                    mask_d  = dec_mask;
                    boot_d  = boot_addr_i;
                    error_d = dec_invalid;
                end
            end
            ST_HALT: begin
                core_debug_req_o = mask_q;
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if ((core_halted_i & mask_q) == mask_q) begin
                    state_d = ST_BOOT;
                    cnt_d   = '0;
                end
            end
            ST_BOOT: begin
                if (cnt_q < RST_LAST) begin
                    core_rst_no = ~mask_q;
                end
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                core_fetch_en_o = mask_q;
                // Abort beats done, and done beats the watchdog.
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if ((done_q & mask_q) == mask_q) begin
                    state_d = ST_DONE;
                end else if (WD_EN && (cnt_q == WD_LAST)) begin
                    state_d = ST_DONE;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                end_sw_o = 1'b1;
                if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign core_boot_addr_o = boot_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign error_o          = error_q;

endmodule

// File: tb/tb_cb_safe_cpu_sequencer.sv
// Randomized scenario bench for cb_safe_cpu_sequencer: a default instance and a
// 4-bit-watchdog instance share stimulus and are checked against a timeline model.
module tb_cb_safe_cpu_sequencer;

    localparam int RSTC     = 8;
    localparam int NO_ABORT = 9999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  master;
    logic        safe_mode;
    logic [1:0]  cfg;
    logic [31:0] boot_addr;
    logic [2:0]  halted;
    logic [2:0]  done;

    logic [2:0]  dbg0, rstn0, fetch0, dbg1, rstn1, fetch1;
    logic [31:0] boot0, boot1;
    logic        endsw0, busy0, err0, endsw1, busy1, err1;
    logic [43:0] obs_vec [2];

    int          n_vec;
    int          n_err;
    logic        err_m  [2];
    logic [31:0] boot_m [2];
    int          wd_max [2];
    int          halt_t   [3];
    int          done_off [3];

    always #5 clk = ~clk;

    cb_safe_cpu_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .master_core_i(master),
        .safe_mode_i(safe_mode), .safe_configuration_i(cfg), .boot_addr_i(boot_addr),
        .core_halted_i(halted), .core_done_i(done),
        .core_debug_req_o(dbg0), .core_rst_no(rstn0), .core_fetch_en_o(fetch0),
        .core_boot_addr_o(boot0), .end_sw_o(endsw0), .busy_o(busy0), .error_o(err0)
    );

    cb_safe_cpu_sequencer #(.TIMEOUT_W(4)) dut_wd (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .master_core_i(master),
        .safe_mode_i(safe_mode), .safe_configuration_i(cfg), .boot_addr_i(boot_addr),
        .core_halted_i(halted), .core_done_i(done),
        .core_debug_req_o(dbg1), .core_rst_no(rstn1), .core_fetch_en_o(fetch1),
        .core_boot_addr_o(boot1), .end_sw_o(endsw1), .busy_o(busy1), .error_o(err1)
    );

    assign obs_vec[0] = {dbg0, rstn0, fetch0, endsw0, busy0, err0, boot0};
    assign obs_vec[1] = {dbg1, rstn1, fetch1, endsw1, busy1, err1, boot1};

    // Active cores: the master, its successor for DMR, all three for TMR.
    function automatic logic [2:0] exp_mask(input logic [2:0] mst, input logic md,
                                            input logic [1:0] c);
        int m;
        int ones;
        m = 0;
        ones = 0;
        for (int i = 0; i < 3; i++) begin
            if (mst[i]) begin
                ones++;
                m = i;
            end
        end
        if (ones != 1) m = 0;
        if (md && c == 2'b01) return 3'((1 << m) | (1 << ((m + 1) % 3)));
        if (md && c == 2'b10) return 3'b111;
        return 3'(1 << m);
    endfunction

    // Cycle k is the interval after the k-th posedge following the start request;
    // start is held through cycle s-1 and dropped in cycle s.
    task automatic run_seq(input string name, input logic [2:0] mst, input logic md,
                           input logic [1:0] c, input logic [31:0] ba, input int stop_rel);
        logic [2:0]  m;
        logic        inv;
        int          h, r0, s, maxoff, jd, jw;
        int          j  [2];
        bit          wd [2];
        logic [2:0]  e_dbg, e_rst, e_fetch;
        logic        e_end, e_busy, e_err;
        logic [31:0] e_boot;
        logic [43:0] e_vec;
        m      = exp_mask(mst, md, c);
        inv    = ($countones(mst) != 1);
        h      = 1;
        maxoff = 0;
        for (int i = 0; i < 3; i++) begin
            if (m[i]) begin
                if (halt_t[i] > h) h = halt_t[i];
                if (done_off[i] > maxoff) maxoff = done_off[i];
            end
        end
        r0 = h + RSTC + 2;
        for (int d = 0; d < 2; d++) begin
            jd    = r0 + maxoff + 1;
            jw    = r0 + wd_max[d] - 1;
            j[d]  = (jw < jd) ? jw : jd;
            wd[d] = (jw < jd);
        end
        if (stop_rel == NO_ABORT) s = ((j[0] > j[1]) ? j[0] : j[1]) + 3;
        else s = (r0 + stop_rel < 1) ? 1 : r0 + stop_rel;

        for (int k = -2; k <= s + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                start = 1'b1; master = mst; safe_mode = md; cfg = c; boot_addr = ba;
            end else begin
                start     = (k > 0) && (k < s);
                master    = 3'($urandom);
                safe_mode = 1'($urandom);
                cfg       = 2'($urandom);
                boot_addr = $urandom;
            end
            for (int i = 0; i < 3; i++) begin
                halted[i] = m[i] ? (k >= 1 && k >= halt_t[i]) : 1'($urandom);
                done[i]   = m[i] ? (k >= r0 + done_off[i]) : 1'($urandom);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (k <= 0 || k > s) begin
                    e_dbg = 3'b000; e_rst = 3'b111; e_fetch = 3'b000;
                    e_end = 1'b0;   e_busy = 1'b0;
                end else begin
                    e_dbg   = (k <= h) ? m : 3'b000;
                    e_rst   = (k > h && k <= h + RSTC) ? ~m : 3'b111;
                    e_fetch = (k >= r0 && k <= j[d]) ? m : 3'b000;
                    e_end   = (k > j[d]);
                    e_busy  = 1'b1;
                end
                e_err  = (k <= 0) ? err_m[d] : (inv | (wd[d] && j[d] < s && k > j[d]));
                e_boot = (k <= 0) ? boot_m[d] : ba;
                e_vec  = {e_dbg, e_rst, e_fetch, e_end, e_busy, e_err, e_boot};
                n_vec++;
                if (obs_vec[d] !== e_vec) begin
                    n_err++;
                    $display("[TB] FAIL %s dut%0d cycle %0d: got dbg=%b rst_n=%b fetch=%b end_sw=%b busy=%b err=%b boot=%h, expected dbg=%b rst_n=%b fetch=%b end_sw=%b busy=%b err=%b boot=%h",
                             name, d, k, obs_vec[d][43:41], obs_vec[d][40:38], obs_vec[d][37:35],
                             obs_vec[d][34], obs_vec[d][33], obs_vec[d][32], obs_vec[d][31:0],
                             e_dbg, e_rst, e_fetch, e_end, e_busy, e_err, e_boot);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            err_m[d]  = inv | (wd[d] && j[d] < s);
            boot_m[d] = ba;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; master = 3'b001; safe_mode = 1'b0; cfg = 2'b00;
        boot_addr = 32'hDEAD_BEEF; halted = 3'b111; done = 3'b111;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs_vec[d] !== {3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0}) begin
                n_err++;
                $display("[TB] FAIL reset_values dut%0d: got %h, expected %h", d, obs_vec[d],
                         {3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0});
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (obs_vec[d][33] !== 1'b0 || obs_vec[d][43:41] !== 3'b000) begin
                    n_err++;
                    $display("[TB] FAIL start_held_through_reset dut%0d cycle %0d: got busy=%b dbg=%b, expected busy=0 dbg=000",
                             d, k, obs_vec[d][33], obs_vec[d][43:41]);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            err_m[d]  = 1'b0;
            boot_m[d] = 32'h0;
        end
    endtask

    task automatic test_single_core();
        halt_t   = '{3, 1, 1};
        done_off = '{50, 0, 0};
        run_seq("single_core", 3'b001, 1'b0, 2'b00, 32'h1C00_0080, NO_ABORT);
    endtask

    task automatic test_dmr();
        halt_t   = '{1, int'($urandom_range(1, 4)), int'($urandom_range(1, 4))};
        done_off = '{0, 3, 10};
        run_seq("dmr", 3'b010, 1'b1, 2'b01, $urandom, NO_ABORT);
    endtask

    task automatic test_abort_run();
        halt_t   = '{2, 1, 3};
        done_off = '{1000, 1000, 1000};
        run_seq("abort_run", 3'b001 << $urandom_range(0, 2), 1'b1, 2'b10, $urandom, 5);
    endtask

    task automatic test_watchdog();
        halt_t   = '{1, 2, 1};
        done_off = '{1000, 1000, 1000};
        run_seq("watchdog_expiry", 3'b100, 1'b1, 2'b10, $urandom, 20);
        done_off = '{13, 13, 13};
        run_seq("watchdog_tie_done_wins", 3'b001 << $urandom_range(0, 2), 1'b1, 2'b10,
                $urandom, NO_ABORT);
    endtask

    task automatic test_invalid_master();
        halt_t   = '{2, 1, 1};
        done_off = '{4, 0, 0};
        run_seq("invalid_master", 3'b011, 1'($urandom), 2'b00, $urandom, NO_ABORT);
    endtask

    task automatic test_reset_in_boot();
        logic [31:0] ba;
        ba = $urandom;
        repeat (2) begin
            @(posedge clk); #1;
            start = 1'b0; halted = 3'b000; done = 3'b000;
        end
        @(posedge clk); #1;
        start = 1'b1; master = 3'b100; safe_mode = 1'b0; cfg = 2'b00; boot_addr = ba;
        @(posedge clk); #1;
        halted = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (rstn0 !== 3'b011) begin
            n_err++;
            $display("[TB] FAIL boot_rst_low: got rst_n=%b, expected 011", rstn0);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs_vec[d] !== {3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0}) begin
                n_err++;
                $display("[TB] FAIL async_reset_in_boot dut%0d: got %h, expected %h", d, obs_vec[d],
                         {3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs_vec[d][33] !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL idle_after_reset dut%0d: got busy=%b, expected 0", d, obs_vec[d][33]);
            end
            err_m[d]  = 1'b0;
            boot_m[d] = 32'h0;
        end
    endtask

    task automatic test_random();
        logic [2:0] mst;
        int         stop_rel;
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 7) < 6) mst = 3'b001 << $urandom_range(0, 2);
            else mst = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                halt_t[i]   = $urandom_range(1, 5);
                done_off[i] = $urandom_range(0, 18);
            end
            if ($urandom_range(0, 1) == 0) stop_rel = NO_ABORT;
            else stop_rel = int'($urandom_range(0, 40)) - 12;
            run_seq("random", mst, 1'($urandom), 2'($urandom), $urandom, stop_rel);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        wd_max[0] = (1 << 24) - 1;
        wd_max[1] = 15;
        rst_n     = 1'b0;
        start     = 1'b0;
        master    = 3'b001;
        safe_mode = 1'b0;
        cfg       = 2'b00;
        boot_addr = 32'h0;
        halted    = 3'b000;
        done      = 3'b000;
        test_reset();
        test_single_core();
        test_dmr();
        test_abort_run();
        test_watchdog();
        test_invalid_master();
        test_reset_in_boot();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
